f2h_sdram_arbiter: RTL



---
 rtl/f2h_sdram_arbiter_if.sv | 33 +++
 rtl/f2h_sdram_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/f2h_sdram_arbiter_if.sv
// ---------------------------------------------------------------------------
// f2h_sdram_arbiter_if
// Avalon-MM command/response bundle used on both sides of the arbiter.
//   master modport : drives the command (address, burstcount, read, write,
//                    writedata, byteenable) and receives waitrequest,
//                    readdata and readdatavalid.
//   slave modport  : the mirror image.
// ---------------------------------------------------------------------------
interface f2h_sdram_arbiter_if #(
   parameter int unsigned AW  = 30,
   parameter int unsigned DW  = 32,
   parameter int unsigned BCW = 8
);
   logic [AW-1:0]   address;
   logic [BCW-1:0]  burstcount;
   logic            read;
   logic            write;
   logic [DW-1:0]   writedata;
   logic [DW/8-1:0] byteenable;
   logic            waitrequest;
   logic [DW-1:0]   readdata;
   logic            readdatavalid;

   modport master (
      output address, burstcount, read, write, writedata, byteenable,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, burstcount, read, write, writedata, byteenable,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/f2h_sdram_arbiter.sv
// ---------------------------------------------------------------------------
// f2h_sdram_arbiter
// Round-robin arbiter sharing one HPS f2h_sdram0 Avalon-MM port between two
// masters (m0: CPU memory bridge, m1: video/DMA prefetcher). Write bursts are
// atomic; a tag FIFO of outstanding reads routes returning beats.
// Ports:
//   clk_i      sdram_clk
//   rst_i      synchronous active-high reset
//   m0, m1     slave side of the two masters' Avalon-MM buses
//   s          master side towards f2h_sdram0
//   rd_orphan  sticky flag: readdatavalid arrived with no outstanding read
// ---------------------------------------------------------------------------
module f2h_sdram_arbiter #(
   parameter int unsigned AW    = 30,
   parameter int unsigned DW    = 32,
   parameter int unsigned BCW   = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   f2h_sdram_arbiter_if.slave  m0,
   f2h_sdram_arbiter_if.slave  m1,
   f2h_sdram_arbiter_if.master s,
   output logic                rd_orphan
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      WBURST = 2'd2
   } state_t;

   state_t          r_state;
   logic            r_gnt;
   logic            r_rr_last;
   logic [BCW-1:0]  r_wr_left;
   logic            r_rd_orphan;

   // read tag FIFO: issuing master id and remaining beat count per entry
   logic            r_fifo_id  [DEPTH];
   logic [BCW-1:0]  r_fifo_cnt [DEPTH];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;

   logic            w_fifo_full;
   logic            w_fifo_empty;
   logic            w_elig0;
   logic            w_elig1;
   logic            w_active;
   logic [AW-1:0]   w_g_address;
   logic [BCW-1:0]  w_g_burstcount;
   logic            w_g_read;
   logic            w_g_write;
   logic [DW-1:0]   w_g_writedata;
   logic [DW/8-1:0] w_g_byteenable;
   logic            w_s_read;
   logic            w_s_write;
   logic            w_rd_acc;
   logic            w_wr_acc;
   logic            w_head_id;
   logic            w_rdv_hit;
   logic            w_push;
   logic            w_pop;

   // occupancy is the registered count, so a same-cycle pop never frees a slot
   assign w_fifo_full  = (r_count == CW'(DEPTH));
   assign w_fifo_empty = (r_count == '0);

   assign w_elig0 = (m0.read && !w_fifo_full) || m0.write;
   assign w_elig1 = (m1.read && !w_fifo_full) || m1.write;

   assign w_active = (r_state == GRANT) || (r_state == WBURST);

   // granted master's command
   assign w_g_address    = r_gnt ? m1.address    : m0.address;
   assign w_g_burstcount = r_gnt ? m1.burstcount : m0.burstcount;
   assign w_g_read       = r_gnt ? m1.read       : m0.read;
   assign w_g_write      = r_gnt ? m1.write      : m0.write;
   assign w_g_writedata  = r_gnt ? m1.writedata  : m0.writedata;
   assign w_g_byteenable = r_gnt ? m1.byteenable : m0.byteenable;

   // reads are only forwarded from GRANT; a read inside a write burst is ignored
   assign w_s_read  = (r_state == GRANT) && w_g_read;
   assign w_s_write = w_active && w_g_write;

   // slave-side command, zero whenever nothing is granted
   always_comb begin
      s.address    = '0;
      s.burstcount = '0;
      s.writedata  = '0;
      s.byteenable = '0;
      s.read       = w_s_read;
      s.write      = w_s_write;
      if (w_active) begin
         s.address    = w_g_address;
         s.burstcount = w_g_burstcount;
         s.writedata  = w_g_writedata;
         s.byteenable = w_g_byteenable;
      end
   end

   assign w_rd_acc = w_s_read  && !s.waitrequest;
   assign w_wr_acc = w_s_write && !s.waitrequest;

   // a read strobe during the burst must not see an accept
   assign m0.waitrequest = !(w_active && !r_gnt) || s.waitrequest ||
                           ((r_state == WBURST) && m0.read);
   assign m1.waitrequest = !(w_active &&  r_gnt) || s.waitrequest ||
                           ((r_state == WBURST) && m1.read);

   // zero-latency read return steered by the FIFO head
   assign w_head_id = r_fifo_id[r_rd_ptr];
   assign w_rdv_hit = s.readdatavalid && !w_fifo_empty;
   assign w_push    = w_rd_acc;
   assign w_pop     = w_rdv_hit && (r_fifo_cnt[r_rd_ptr] == BCW'(1));

   assign m0.readdata      = s.readdata;
   assign m1.readdata      = s.readdata;
   assign m0.readdatavalid = w_rdv_hit && !w_head_id;
   assign m1.readdatavalid = w_rdv_hit &&  w_head_id;

   assign rd_orphan = r_rd_orphan;

   // arbitration FSM, tag FIFO and orphan flag
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= IDLE;
         r_gnt       <= 1'b0;
         r_rr_last   <= 1'b1;
         r_wr_left   <= '0;
         r_rd_orphan <= 1'b0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_elig0 || w_elig1) begin
                  r_gnt   <= (w_elig0 && w_elig1) ? !r_rr_last : w_elig1;
                  r_state <= GRANT;
               end
            end
            GRANT: begin
               if (w_rd_acc) begin
                  r_rr_last <= r_gnt;
                  r_state   <= IDLE;
               end else if (w_wr_acc) begin
                  if (w_g_burstcount > BCW'(1)) begin
                     r_wr_left <= BCW'(w_g_burstcount - BCW'(1));
                     r_state   <= WBURST;
                  end else begin
                     r_rr_last <= r_gnt;
                     r_state   <= IDLE;
                  end
               end
            end
            WBURST: begin
               if (w_wr_acc) begin
                  r_wr_left <= BCW'(r_wr_left - BCW'(1));
                  if (r_wr_left == BCW'(1)) begin
                     r_rr_last <= r_gnt;
                     r_state   <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase

         // push never targets the head entry being decremented: a push only
         // happens when the FIFO was not full at arbitration time
         if (w_push) begin
            r_fifo_id[r_wr_ptr]  <= r_gnt;
            r_fifo_cnt[r_wr_ptr] <= w_g_burstcount;
            r_wr_ptr             <= PW'(r_wr_ptr + PW'(1));
         end

         if (w_rdv_hit) begin
            if (w_pop) begin
               r_rd_ptr <= PW'(r_rd_ptr + PW'(1));
            end else begin
               r_fifo_cnt[r_rd_ptr] <= BCW'(r_fifo_cnt[r_rd_ptr] - BCW'(1));
            end
         end

         case ({w_push, w_pop})
            2'b10:   r_count <= CW'(r_count + CW'(1));
            2'b01:   r_count <= CW'(r_count - CW'(1));
            default: r_count <= r_count;
         endcase

         if (s.readdatavalid && w_fifo_empty) begin
            r_rd_orphan <= 1'b1;
         end
      end
   end

endmodule
